// File: rtl/iot_monitor_multi.sv
// Multi-channel active-device counter with saturation, peak tracking,
// sticky overflow/underflow flags and a hysteresis alarm.
module iot_monitor_multi #(
  parameter int WIDTH     = 8,
  parameter int CHANNELS  = 4,
  parameter int MAX_COUNT = 255,
  parameter int HI_THRESH = 200,
  parameter int LO_THRESH = 150
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] change,
  input  logic [CHANNELS-1:0] on_off,
  input  logic                clear_flags,
  output logic [WIDTH-1:0]    counter_out,
  output logic [WIDTH-1:0]    peak_out,
  output logic                alarm,
  output logic                overflow,
  output logic                underflow
);

  localparam int CW = $clog2(CHANNELS + 1);
  localparam int RW = WIDTH + CW + 1;

  localparam logic signed [RW-1:0] MAX_S  = RW'(MAX_COUNT);
  localparam logic [WIDTH-1:0]     MAX_W  = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0]     HI_W   = WIDTH'(HI_THRESH);
  localparam logic [WIDTH-1:0]     LO_W   = WIDTH'(LO_THRESH);

  typedef enum logic {
    NORMAL = 1'b0,
    ALARM  = 1'b1
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]          inc;
  logic [CW-1:0]          dec;
  logic signed [RW-1:0]   raw;
  logic                   clip_hi;
  logic                   clip_lo;
  logic [WIDTH-1:0]       next_count;

  always_comb begin
    inc = '0;
    dec = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (change[i]) begin
        if (on_off[i]) inc = inc + 1'b1;
        else           dec = dec + 1'b1;
      end
    end
  end

  // Both operands are zero-extended into a sign bit of headroom, so the
  // sum can neither wrap above MAX_COUNT nor below zero before clipping.
  always_comb begin
    raw = signed'({{(CW + 1){1'b0}}, counter_out})
        + signed'({{(WIDTH + 1){1'b0}}, inc})
        - signed'({{(WIDTH + 1){1'b0}}, dec});
    clip_hi = (raw > MAX_S);
    clip_lo = raw[RW-1];
    if (clip_hi)      next_count = MAX_W;
    else if (clip_lo) next_count = '0;
    else              next_count = raw[WIDTH-1:0];
  end

  always_comb begin
    state_next = state;
    case (state)
      NORMAL:  if (next_count >= HI_W) state_next = ALARM;
      ALARM:   if (next_count <= LO_W) state_next = NORMAL;
      default: state_next = NORMAL;
    endcase
  end

  assign alarm = (state == ALARM);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= NORMAL;
      counter_out <= '0;
      peak_out    <= '0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      state       <= state_next;
      counter_out <= next_count;
      if (clear_flags || (next_count > peak_out)) peak_out <= next_count;
      // A clip in the clearing cycle still leaves its flag set.
      overflow    <= (overflow  & ~clear_flags) | clip_hi;
      underflow   <= (underflow & ~clear_flags) | clip_lo;
    end
  end

endmodule

// File: tb/tb_iot_monitor_multi.sv
// Self-checking bench: a default instance and a small-bound instance share
// stimulus; both are checked every cycle against an arithmetic model.
module tb_iot_monitor_multi;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] change = '0;
  logic [3:0] on_off = '0;
  logic       clear_flags = 1'b0;

  logic [7:0] cnt_a, peak_a, cnt_b, peak_b;
  logic       al_a, ov_a, un_a, al_b, ov_b, un_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  iot_monitor_multi dut_a (
    .clk(clk), .rst(rst), .change(change), .on_off(on_off),
    .clear_flags(clear_flags), .counter_out(cnt_a), .peak_out(peak_a),
    .alarm(al_a), .overflow(ov_a), .underflow(un_a)
  );

  iot_monitor_multi #(.WIDTH(8), .CHANNELS(4), .MAX_COUNT(20),
                      .HI_THRESH(12), .LO_THRESH(8)) dut_b (
    .clk(clk), .rst(rst), .change(change), .on_off(on_off),
    .clear_flags(clear_flags), .counter_out(cnt_b), .peak_out(peak_b),
    .alarm(al_b), .overflow(ov_b), .underflow(un_b)
  );

  typedef struct {
    int cnt;
    int peak;
    bit al;
    bit ov;
    bit un;
  } mstate_t;

  typedef struct {
    bit       r;
    bit [3:0] ch;
    bit [3:0] oo;
    bit       clr;
    int       cnt;
    int       peak;
    bit       al;
    bit       ov;
    bit       un;
  } vec_t;

  mstate_t ma, mb;
  vec_t    tbl[$];

  function automatic mstate_t mstep(mstate_t s, bit r, bit [3:0] ch, bit [3:0] oo,
                                    bit clr, int maxc, int hi, int lo);
    mstate_t n;
    int raw, nc;
    if (r) begin
      n.cnt = 0; n.peak = 0; n.al = 0; n.ov = 0; n.un = 0;
      return n;
    end
    raw = s.cnt + $countones(ch & oo) - $countones(ch & ~oo);
    nc  = (raw > maxc) ? maxc : ((raw < 0) ? 0 : raw);
    n.cnt  = nc;
    n.peak = clr ? nc : ((nc > s.peak) ? nc : s.peak);
    n.ov   = (clr ? 1'b0 : s.ov) | (raw > maxc);
    n.un   = (clr ? 1'b0 : s.un) | (raw < 0);
    if (!s.al && nc >= hi)     n.al = 1;
    else if (s.al && nc <= lo) n.al = 0;
    else                       n.al = s.al;
    return n;
  endfunction

  function automatic logic [18:0] pack(int c, int p, bit a, bit o, bit u);
    return {8'(c), 8'(p), a, o, u};
  endfunction

  function automatic void add(bit r, bit [3:0] ch, bit [3:0] oo, bit clr,
                              int c, int p, bit a, bit o, bit u);
    vec_t v;
    v.r = r; v.ch = ch; v.oo = oo; v.clr = clr;
    v.cnt = c; v.peak = p; v.al = a; v.ov = o; v.un = u;
    tbl.push_back(v);
  endfunction

  task automatic check(string name, logic [18:0] act, logic [18:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got {cnt,peak,al,ov,un}=%h/%h/%b%b%b expected %h/%h/%b%b%b",
               name, act[18:11], act[10:3], act[2], act[1], act[0],
               exp[18:11], exp[10:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic apply(bit r, bit [3:0] ch, bit [3:0] oo, bit clr);
    rst = r; change = ch; on_off = oo; clear_flags = clr;
    @(posedge clk);
    #1;
    ma = mstep(ma, r, ch, oo, clr, 255, 200, 150);
    mb = mstep(mb, r, ch, oo, clr, 20, 12, 8);
    check("model_a", pack(cnt_a, peak_a, al_a, ov_a, un_a),
          pack(ma.cnt, ma.peak, ma.al, ma.ov, ma.un));
    check("model_b", pack(cnt_b, peak_b, al_b, ov_b, un_b),
          pack(mb.cnt, mb.peak, mb.al, mb.ov, mb.un));
  endtask

  initial begin
    int c;
    bit [3:0] ch, oo;
    int bias;

    // Expected values below are for dut_b (MAX=20, HI=12, LO=8).
    for (int i = 0; i < 3; i++) add(1, 4'hF, 4'hF, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 10; i++) add(0, 4'hF, 4'h7, 0, 2*i, 2*i, (2*i >= 12), 0, 0);
    add(0, 4'h3, 4'h0, 0, 18, 20, 1, 0, 0);
    add(0, 4'h3, 4'h0, 0, 16, 20, 1, 0, 0);
    add(0, 4'h3, 4'h0, 0, 14, 20, 1, 0, 0);
    add(1, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 6; i++) begin
      c = (4*i > 20) ? 20 : 4*i;
      add(0, 4'hF, 4'hF, 0, c, c, (c >= 12), (i == 6), 0);
    end
    for (int i = 1; i <= 6; i++) begin
      c = (20 - 4*i < 0) ? 0 : 20 - 4*i;
      add(0, 4'hF, 4'h0, 0, c, 20, (c > 8), 1, (i == 6));
    end
    add(0, 4'h0, 4'h0, 1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 12; i++) add(0, 4'h1, 4'h1, 0, i, i, (i >= 12), 0, 0);
    for (int i = 11; i >= 8; i--) add(0, 4'h1, 4'h0, 0, i, 12, (i > 8), 0, 0);
    for (int i = 9; i <= 11; i++) add(0, 4'h1, 4'h1, 0, i, 12, 0, 0, 0);
    add(0, 4'hF, 4'hF, 0, 15, 15, 1, 0, 0);
    add(0, 4'hF, 4'hF, 0, 19, 19, 1, 0, 0);
    add(0, 4'hF, 4'hF, 0, 20, 20, 1, 1, 0);
    add(0, 4'h1, 4'h1, 1, 20, 20, 1, 1, 0);
    add(0, 4'h3, 4'h0, 0, 18, 20, 1, 1, 0);
    add(0, 4'h3, 4'h0, 0, 16, 20, 1, 1, 0);
    add(0, 4'h3, 4'h0, 0, 14, 20, 1, 1, 0);
    add(1, 4'hF, 4'hF, 0, 0, 0, 0, 0, 0);
    add(0, 4'hF, 4'hF, 0, 4, 4, 0, 0, 0);
    add(0, 4'hF, 4'hF, 0, 8, 8, 0, 0, 0);

    ma = '{0, 0, 0, 0, 0};
    mb = '{0, 0, 0, 0, 0};

    foreach (tbl[i]) begin
      apply(tbl[i].r, tbl[i].ch, tbl[i].oo, tbl[i].clr);
      check($sformatf("table[%0d]", i), pack(cnt_b, peak_b, al_b, ov_b, un_b),
            pack(tbl[i].cnt, tbl[i].peak, tbl[i].al, tbl[i].ov, tbl[i].un));
    end

    // Default instance up to the ceiling and back, exercising its thresholds.
    for (int i = 0; i < 70; i++) apply(0, 4'hF, 4'hF, 0);
    for (int i = 0; i < 70; i++) apply(0, 4'hF, 4'h0, 0);
    apply(0, 4'h0, 4'h0, 1);

    // Biased random walk so both instances visit every region.
    for (int ph = 0; ph < 8; ph++) begin
      bias = (ph % 2 == 0) ? 80 : 20;
      for (int i = 0; i < 250; i++) begin
        ch = 4'($urandom);
        for (int b = 0; b < 4; b++) oo[b] = ($urandom_range(0, 99) < bias);
        apply(($urandom_range(0, 199) == 0), ch, oo, ($urandom_range(0, 31) == 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
